uart_rx_ovs: RTL
================

Name: uart_rx_ovs

Overview:
- Oversampling UART receive front-end. Turns the raw RxD pin into framed bytes for the UART peripheral's receive FIFO path.
- Provides a 2-FF synchronizer, a per-frame bit-timing counter, 3-sample majority voting at mid-bit, and start-glitch rejection.
- Detects framing errors and line breaks.
- Emits one-cycle byte strobes that the peripheral's queue FSM consumes directly.

Parameters:
- WIDTH, 32, width of the cycles_per_bit input and the internal bit-period counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- uart_rxd  input  1  raw serial line, idle high, asynchronous to clk.
- uart_rx_en  input  1  receiver enable.
- cycles_per_bit  input  WIDTH  clk cycles per bit period.
- uart_rx_valid  output  1  one-cycle strobe: uart_rx_data holds a good byte.
- uart_rx_data  output  8  last received byte, LSB first on the line.
- uart_rx_break  output  1  line-break indication (level).
- uart_rx_frame_err  output  1  one-cycle strobe: stop bit sampled low with nonzero data.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, counters 0, both synchronizer flops 1, all outputs 0.
- Synchronizer: uart_rxd passes through 2 flops to give rxs. Edge detection compares rxs with its previous value.
- Timing latch: on start detection, P = max(cycles_per_bit, 4) and H = P>>1 are latched. Later changes to cycles_per_bit do not affect the frame in progress.
- Bit counter: cnt counts 0..P-1 within each bit period. cnt=0 in the cycle after the falling edge is detected. At cnt=P-1 it wraps to 0 and the bit index advances.
- Majority vote: rxs is sampled at cnt=H-1, H and H+1. The bit value is the majority of the 3 samples, decided at cnt=H+1.
- States:
  - IDLE: on an rxs 1->0 edge with uart_rx_en=1, go to START.
  - START: at the decision point, a majority of 1 is a false start: go to IDLE with no output. A majority of 0 goes to DATA.
  - DATA: 8 bits shifted LSB first, bit index 0..7. After bit 7's period ends, go to STOP.
  - STOP, at the decision point:
    - stop=1: load uart_rx_data, pulse uart_rx_valid for 1 cycle (the cycle after the decision), go to IDLE immediately without waiting for the rest of the stop bit.
    - stop=0 and data!=0: pulse uart_rx_frame_err for 1 cycle, go to IDLE. uart_rx_data and uart_rx_valid are unchanged.
    - stop=0 and data==0: go to BREAK and set uart_rx_break=1. No valid strobe.
  - BREAK: hold uart_rx_break=1 until rxs==1, then clear it and go to IDLE. No start detection while in BREAK.
- uart_rx_valid and uart_rx_frame_err are never asserted together. Each is never high for more than 1 consecutive cycle.
- Enable low (synchronous): force IDLE, clear uart_rx_break, suppress strobes. uart_rx_data retains its value. A frame in progress is aborted silently.
- Enable low to high while the line is low: no start is detected until an rxs 1->0 edge is seen.
- Back-to-back frames: because STOP exits at mid-stop-bit, a start edge arriving up to H cycles early is still detected.
- Asynchronous reset mid-frame: everything returns to the reset values. The next frame requires a fresh falling edge.
- Counter arithmetic: unsigned, WIDTH bits. H-1 >= 1 is guaranteed by the clamp to 4.

Test Plan:
- cycles_per_bit=217, enable=1, send 0x55 8N1. Expect exactly one valid pulse with data=0x55, rising 9*217+109+3 (+-1) = 2065+-1 cycles after the pin falling edge. frame_err and break stay 0.
- Send 0xA3 then 0x0F back-to-back, stop bit shortened to 120 cycles. Expect two valid pulses with data 0xA3 and 0x0F, in order.
- 50-cycle low glitch on an idle line (P=217). Expect no strobes and state back in IDLE. Then send 0x3C: data=0x3C.
- Send 0x81 with a 1-cycle inverted glitch at mid-bit of bit 0 (cnt=H). Expect data=0x81, because the majority vote recovers the bit.
- Send 0x41 with stop bit low. Expect a frame_err 1-cycle pulse, no valid, and uart_rx_data still holding the previous byte.
- Hold the line low for 12 bit-times, then release. Expect break to rise after the 10th-period decision and fall 3 cycles after the pin goes high, with no valid. Then cycles_per_bit=2: send 0x99 at 4 cycles/bit and expect data=0x99. Repeat with enable dropped mid-frame and separately with resetn pulsed mid-frame: no strobes, and a subsequent clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receive front-end: 2-FF synchronizer, per-frame bit timer,
// 3-sample mid-bit majority vote, false-start rejection, framing error and
// line-break detection. Produces one-cycle byte / framing-error strobes.
module uart_rx_ovs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             uart_rxd,
  input  logic             uart_rx_en,
  input  logic [WIDTH-1:0] cycles_per_bit,
  output logic             uart_rx_valid,
  output logic [7:0]       uart_rx_data,
  output logic             uart_rx_break,
  output logic             uart_rx_frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  state_t           next_state;

  logic             sync_ff;
  logic             rxs;
  logic             rxs_prev;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cpb_clamped;
  logic [2:0]       bit_idx;
  logic             samp0;
  logic             samp1;
  logic [7:0]       shreg;

  logic             fall;
  logic             start_det;
  logic             period_end;
  logic             decide;
  logic             vote;
  logic             in_frame;

  logic             do_valid;
  logic             do_ferr;
  logic             do_brk_set;
  logic             do_brk_clr;

  assign fall        = rxs_prev & ~rxs;
  assign start_det   = (state == S_IDLE) & uart_rx_en & fall;
  assign cpb_clamped = (cycles_per_bit < WIDTH'(4)) ? WIDTH'(4) : cycles_per_bit;
  assign period_end  = (cnt == period - WIDTH'(1));
  assign decide      = (cnt == half + WIDTH'(1));
  assign vote        = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
  assign in_frame    = (state == S_START) | (state == S_DATA) | (state == S_STOP);

  // Bring the asynchronous pin into the clock domain and keep its last value for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_ff  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync_ff  <= uart_rxd;
      rxs      <= sync_ff;
      rxs_prev <= rxs;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a false start wins over the end of the start-bit period
  always_comb begin
    next_state = state;
    if (!uart_rx_en) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (fall) next_state = S_START;
        end
        S_START: begin
          if (decide && vote)  next_state = S_IDLE;
          else if (period_end) next_state = S_DATA;
        end
        S_DATA: begin
          if (period_end && (bit_idx == 3'd7)) next_state = S_STOP;
        end
        S_STOP: begin
          if (decide) begin
            if (vote || (shreg != 8'd0)) next_state = S_IDLE;
            else                         next_state = S_BREAK;
          end
        end
        S_BREAK: begin
          if (rxs) next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Output decode: stop-bit decision outcomes and break release
  always_comb begin
    do_valid   = 1'b0;
    do_ferr    = 1'b0;
    do_brk_set = 1'b0;
    do_brk_clr = 1'b0;
    if (uart_rx_en) begin
      if ((state == S_STOP) && decide) begin
        do_valid   = vote;
        do_ferr    = ~vote & (shreg != 8'd0);
        do_brk_set = ~vote & (shreg == 8'd0);
      end
      do_brk_clr = (state == S_BREAK) & rxs;
    end
  end

  // Registered outputs: strobes last one cycle, data only changes on a good byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
      uart_rx_data      <= 8'd0;
    end else begin
      uart_rx_valid     <= do_valid;
      uart_rx_frame_err <= do_ferr;
      if (do_valid) uart_rx_data <= shreg;
      if (!uart_rx_en || do_brk_clr) uart_rx_break <= 1'b0;
      else if (do_brk_set)          uart_rx_break <= 1'b1;
    end
  end

  // Bit timer, mid-bit samples and data shift register; timing is frozen at start detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      period  <= '0;
      half    <= '0;
      bit_idx <= 3'd0;
      samp0   <= 1'b1;
      samp1   <= 1'b1;
      shreg   <= 8'd0;
    end else if (!uart_rx_en) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else if (start_det) begin
      period  <= cpb_clamped;
      half    <= cpb_clamped >> 1;
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else if (in_frame) begin
      cnt <= period_end ? '0 : cnt + WIDTH'(1);
      if ((state == S_DATA) && period_end) bit_idx <= bit_idx + 3'd1;
      if (cnt == half - WIDTH'(1)) samp0 <= rxs;
      if (cnt == half)             samp1 <= rxs;
      if ((state == S_DATA) && decide) shreg <= {vote, shreg[7:1]};
    end else begin
      cnt <= '0;
    end
  end

endmodule
